// File: rtl/softex_acc_den_accumulator.sv
// Softmax denominator accumulator: sums non-negative exponentiated scores of one row
// with a truncating single-cycle FP adder and hands the total to the inverter.
package softex_acc_den_pkg;
  typedef enum logic [1:0] {
    FP32    = 2'd0,
    FP16    = 2'd1,
    FP8     = 2'd2,
    FP16ALT = 2'd3
  } fp_format_e;

  localparam fp_format_e FPFORMAT_ACC = FP32;

  function automatic int unsigned exp_bits(input fp_format_e f);
    int unsigned r;
    case (f)
      FP32:    r = 32'd8;
      FP16:    r = 32'd5;
      FP8:     r = 32'd5;
      FP16ALT: r = 32'd8;
      default: r = 32'd8;
    endcase
    return r;
  endfunction

  function automatic int unsigned man_bits(input fp_format_e f);
    int unsigned r;
    case (f)
      FP32:    r = 32'd23;
      FP16:    r = 32'd10;
      FP8:     r = 32'd2;
      FP16ALT: r = 32'd7;
      default: r = 32'd23;
    endcase
    return r;
  endfunction

  function automatic int unsigned fp_width(input fp_format_e f);
    return 32'd1 + exp_bits(f) + man_bits(f);
  endfunction
endpackage

module softex_acc_den_accumulator
  import softex_acc_den_pkg::*;
#(
  parameter fp_format_e  FPFORMAT = FPFORMAT_ACC,
  parameter int unsigned CNT_BITS = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            clear_i,
  input  logic                            valid_i,
  output logic                            ready_o,
  input  logic [fp_width(FPFORMAT)-1:0]   data_i,
  input  logic                            last_i,
  output logic                            valid_o,
  input  logic                            ready_i,
  output logic [fp_width(FPFORMAT)-1:0]   den_o,
  output logic [CNT_BITS-1:0]             count_o
);

  localparam int unsigned EXP   = exp_bits(FPFORMAT);
  localparam int unsigned MANT  = man_bits(FPFORMAT);
  localparam int unsigned WIDTH = fp_width(FPFORMAT);
  localparam logic [WIDTH-1:0] POS_INF = {1'b0, {EXP{1'b1}}, {MANT{1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic               hs_s;

  // Sign-less truncating addition; denormals count as zero, inf/NaN saturate to +inf.
  function automatic logic [WIDTH-1:0] fp_add_pos(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    logic [EXP-1:0]  ea, eb, e_big, e_sml, diff, e_res;
    logic [MANT:0]   sa, sb, s_big, s_sml, s_shift;
    logic [MANT+1:0] sum;
    logic [WIDTH-1:0] res;
    ea      = a[WIDTH-2 -: EXP];
    eb      = b[WIDTH-2 -: EXP];
    sa      = {1'b1, a[MANT-1:0]};
    sb      = {1'b1, b[MANT-1:0]};
    e_big   = ea;
    e_sml   = eb;
    s_big   = sa;
    s_sml   = sb;
    diff    = '0;
    s_shift = '0;
    sum     = '0;
    e_res   = '0;
    res     = '0;
    if ((ea == {EXP{1'b1}}) || (eb == {EXP{1'b1}})) begin
      res = POS_INF;
    end else if ((ea == '0) && (eb == '0)) begin
      res = '0;
    end else if (ea == '0) begin
      res = {1'b0, b[WIDTH-2:0]};
    end else if (eb == '0) begin
      res = {1'b0, a[WIDTH-2:0]};
    end else begin
      if (eb > ea) begin
        e_big = eb;
        e_sml = ea;
        s_big = sb;
        s_sml = sa;
      end else begin
        e_big = ea;
        e_sml = eb;
        s_big = sa;
        s_sml = sb;
      end
      diff    = e_big - e_sml;
      s_shift = (32'(diff) > (MANT + 32'd1)) ? '0 : (s_sml >> diff);
      sum     = {1'b0, s_big} + {1'b0, s_shift};
      e_res   = e_big;
      if (sum[MANT+1]) begin
        sum   = sum >> 1;
        e_res = e_big + {{(EXP-1){1'b0}}, 1'b1};
      end else begin
        e_res = e_big;
      end
      if (e_res == {EXP{1'b1}}) begin
        res = POS_INF;
      end else begin
        res = {1'b0, e_res, sum[MANT-1:0]};
      end
    end
    return res;
  endfunction

  assign ready_o = (state_q != OUT);
  assign valid_o = (state_q == OUT);
  assign den_o   = acc_q;
  assign count_o = cnt_q;
  assign hs_s    = valid_i & ready_o;

  // Next-state, accumulator and element-count logic.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (hs_s) begin
          acc_d   = fp_add_pos('0, data_i);
          cnt_d   = {{(CNT_BITS-1){1'b0}}, 1'b1};
          state_d = last_i ? OUT : ACC;
        end else begin
          state_d = IDLE;
        end
      end
      ACC: begin
        if (hs_s) begin
          acc_d   = fp_add_pos(acc_q, data_i);
          cnt_d   = (cnt_q == {CNT_BITS{1'b1}}) ? cnt_q
                                                : cnt_q + {{(CNT_BITS-1){1'b0}}, 1'b1};
          state_d = last_i ? OUT : ACC;
        end else begin
          state_d = ACC;
        end
      end
      OUT: begin
        if (ready_i) begin
          state_d = IDLE;
        end else begin
          state_d = OUT;
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers; reset outranks clear, clear outranks any handshake.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else if (clear_i) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_softex_acc_den_accumulator.sv
// Directed bench for the softmax denominator accumulator (FP32, 16-bit counter).
module tb_softex_acc_den_accumulator;

  logic        clk_i;
  logic        rst_ni;
  logic        clear_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] data_i;
  logic        last_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] den_o;
  logic [15:0] count_o;

  int n_checks = 0;
  int n_errors = 0;

  softex_acc_den_accumulator dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (data_i),
    .last_i  (last_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .den_o   (den_o),
    .count_o (count_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    valid_i = 1'b1;
    data_i  = d;
    last_i  = l;
    step();
    valid_i = 1'b0;
    last_i  = 1'b0;
    data_i  = 32'h0000_0000;
  endtask

  task automatic drain();
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
  endtask

  initial begin
    rst_ni  = 1'b0;
    clear_i = 1'b0;
    valid_i = 1'b0;
    data_i  = 32'h0000_0000;
    last_i  = 1'b0;
    ready_i = 1'b0;
    step();
    step();
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_den",   den_o,        32'h0000_0000);
    check("rst_count", 32'(count_o), 32'd0);
    rst_ni = 1'b1;

    // 1.0 + 1.0
    send(32'h3F80_0000, 1'b0);
    check("t1_mid_valid", 32'(valid_o), 32'd0);
    check("t1_mid_den",   den_o,        32'h3F80_0000);
    check("t1_mid_count", 32'(count_o), 32'd1);
    send(32'h3F80_0000, 1'b1);
    check("t1_valid", 32'(valid_o), 32'd1);
    check("t1_ready", 32'(ready_o), 32'd0);
    check("t1_den",   den_o,        32'h4000_0000);
    check("t1_count", 32'(count_o), 32'd2);
    drain();
    check("t1_idle_valid", 32'(valid_o), 32'd0);
    check("t1_idle_ready", 32'(ready_o), 32'd1);
    check("t1_idle_den",   den_o,        32'h4000_0000);
    check("t1_idle_count", 32'(count_o), 32'd2);

    // 1.5 + 2.5 + 4.0 = 8.0
    send(32'h3FC0_0000, 1'b0);
    send(32'h4020_0000, 1'b0);
    check("t2_mid_den", den_o, 32'h4080_0000);
    send(32'h4080_0000, 1'b1);
    check("t2_den",   den_o,        32'h4100_0000);
    check("t2_count", 32'(count_o), 32'd3);
    drain();

    // 1.0 + 2^-30 falls below the alignment window
    send(32'h3F80_0000, 1'b0);
    send(32'h3080_0000, 1'b1);
    check("t3_den", den_o, 32'h3F80_0000);
    drain();

    // overflow to +inf, then a fresh row restarts
    send(32'h7F7F_FFFF, 1'b0);
    send(32'h7F7F_FFFF, 1'b1);
    check("t4_den", den_o, 32'h7F80_0000);
    drain();
    send(32'h3F80_0000, 1'b1);
    check("t4_restart_den",   den_o,        32'h3F80_0000);
    check("t4_restart_count", 32'(count_o), 32'd1);
    drain();

    // back-pressure in OUT with ignored input pulses
    send(32'h4040_0000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      valid_i = i[0];
      last_i  = 1'b1;
      data_i  = 32'h3F80_0000;
      step();
      check("t5_hold_valid", 32'(valid_o), 32'd1);
      check("t5_hold_ready", 32'(ready_o), 32'd0);
      check("t5_hold_den",   den_o,        32'h4040_0000);
      check("t5_hold_count", 32'(count_o), 32'd1);
    end
    valid_i = 1'b0;
    last_i  = 1'b0;
    drain();
    check("t5_release_valid", 32'(valid_o), 32'd0);
    check("t5_release_ready", 32'(ready_o), 32'd1);

    // clear wins over a simultaneous handshake
    send(32'h3F80_0000, 1'b0);
    clear_i = 1'b1;
    send(32'h4000_0000, 1'b1);
    clear_i = 1'b0;
    check("t6_clr_den",   den_o,        32'h0000_0000);
    check("t6_clr_count", 32'(count_o), 32'd0);
    check("t6_clr_valid", 32'(valid_o), 32'd0);
    check("t6_clr_ready", 32'(ready_o), 32'd1);
    send(32'h4040_0000, 1'b1);
    check("t6_den",   den_o,        32'h4040_0000);
    check("t6_count", 32'(count_o), 32'd1);
    check("t6_valid", 32'(valid_o), 32'd1);
    drain();

    // denormal flushed, sign ignored
    send(32'h0040_0000, 1'b0);
    check("t7_denorm_den",   den_o,        32'h0000_0000);
    check("t7_denorm_count", 32'(count_o), 32'd1);
    send(32'hBF80_0000, 1'b1);
    check("t7_sign_den",   den_o,        32'h3F80_0000);
    check("t7_sign_count", 32'(count_o), 32'd2);
    drain();

    // reset mid-row with a handshake pending discards the partial sum
    send(32'h3F80_0000, 1'b0);
    rst_ni = 1'b0;
    send(32'h4000_0000, 1'b1);
    rst_ni = 1'b1;
    check("t8_rst_den",   den_o,        32'h0000_0000);
    check("t8_rst_count", 32'(count_o), 32'd0);
    check("t8_rst_valid", 32'(valid_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
